// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the control FSM state type.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mduState_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the MDU datapath: shift-add multiply on
// {acc, multiplier} or restoring divide on {rem, quotient}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_divMode,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  // The partial remainder is always below the divisor, so the shifted
  // value fits in WIDTH+1 bits and a successful subtract fits in WIDTH.
  always_comb begin
    w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
    w_shifted = {i_hi, i_lo[WIDTH-1]};
    w_diff    = w_shifted[WIDTH-1:0] - i_operand;
    o_hi      = w_sum[WIDTH:1];
    o_lo      = {w_sum[0], i_lo[WIDTH-1:1]};
    if (i_divMode) begin
      if (w_shifted >= {1'b0, i_operand}) begin
        o_hi = w_diff;
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_shifted[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one datapath
// iteration per cycle, sign correction in FIX, one-cycle done pulse.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             hi_we_in,
  input  logic             lo_we_in,
  input  logic             flush_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mduState_t          r_state, w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_low, r_operand, r_hi, r_lo;
  logic               r_divMode, r_negQ, r_negR, r_divZero;
  logic               w_signA, w_signB, w_divZero, w_accept, w_mtWrite;
  logic [WIDTH-1:0]   w_absA, w_absB, w_stepHi, w_stepLo;
  logic [2*WIDTH-1:0] w_fixProd;

  // MULT and DIV (op bit 0 clear) are the signed operations.
  assign w_signA   = ~op_in[0] & A_in[WIDTH-1];
  assign w_signB   = ~op_in[0] & B_in[WIDTH-1];
  assign w_absA    = w_signA ? -A_in : A_in;
  assign w_absB    = w_signB ? -B_in : B_in;
  assign w_divZero = op_in[1] && (B_in == '0);
  assign w_accept  = (r_state == IDLE) && start_in && !flush_in;
  assign w_mtWrite = (r_state == IDLE) && !start_in;
  assign w_fixProd = r_negQ ? -{r_acc, r_low} : {r_acc, r_low};

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_divMode (r_divMode),
    .i_hi      (r_acc),
    .i_lo      (r_low),
    .i_operand (r_operand),
    .o_hi      (w_stepHi),
    .o_lo      (w_stepLo)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_nextState;
  end

  // A zero divisor still spends one RUN cycle, then bypasses iteration and FIX.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = RUN;
      RUN: begin
        if (flush_in)                     w_nextState = IDLE;
        else if (r_divZero)               w_nextState = DONE;
        else if (r_cnt == CNT_W'(1))      w_nextState = FIX;
      end
      FIX:     w_nextState = flush_in ? IDLE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (r_state == RUN) || (r_state == FIX);
    done_out = (r_state == DONE);
    err_out  = (r_state == DONE) && r_divZero;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_low     <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divMode <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divMode <= op_in[1];
            r_negQ    <= w_signA ^ w_signB;
            r_negR    <= w_signA;
            r_divZero <= w_divZero;
            r_cnt     <= CNT_W'(WIDTH);
            r_acc     <= '0;
            r_low     <= op_in[1] ? w_absA : w_absB;
            r_operand <= op_in[1] ? w_absB : w_absA;
          end else if (w_mtWrite) begin
            if (hi_we_in) r_hi <= A_in;
            if (lo_we_in) r_lo <= A_in;
          end
        end
        RUN: begin
          if (!flush_in && !r_divZero) begin
            r_acc <= w_stepHi;
            r_low <= w_stepLo;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush_in) begin
            if (r_divMode) begin
              r_lo <= r_negQ ? -r_low : r_low;
              r_hi <= r_negR ? -r_acc : r_acc;
            end else begin
              r_hi <= w_fixProd[2*WIDTH-1:WIDTH];
              r_lo <= w_fixProd[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign HI_out = r_hi;
  assign LO_out = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: arithmetic results, latency, divide by
// zero, MTHI/MTLO, flush and asynchronous reset behaviour.
module tb_mdu_iter;

  localparam int WIDTH = 32;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              start_in;
  logic [1:0]        op_in;
  logic [WIDTH-1:0]  A_in, B_in;
  logic              hi_we_in, lo_we_in, flush_in;
  logic              busy_out, done_out, err_out;
  logic [WIDTH-1:0]  HI_out, LO_out;

  int vecCount  = 0;
  int missCount = 0;

  mdu_iter #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (start_in),
    .op_in    (op_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .hi_we_in (hi_we_in),
    .lo_we_in (lo_we_in),
    .flush_in (flush_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .err_out  (err_out),
    .HI_out   (HI_out),
    .LO_out   (LO_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a start for one cycle; returns at the falling edge after edge 0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic loWe);
    @(negedge clk_in);
    start_in = 1'b1;
    op_in    = op;
    A_in     = a;
    B_in     = b;
    lo_we_in = loWe;
    @(negedge clk_in);
    start_in = 1'b0;
    lo_we_in = 1'b0;
  endtask

  // Waits (bounded) for done; checks the edge it arrived on, busy length,
  // results, and that done/err drop after one cycle.
  task automatic waitDone(input string tag, input int expEdge, input int expBusy,
                          input logic [31:0] expHi, input logic [31:0] expLo,
                          input logic expErr);
    int  doneEdge   = 0;
    int  busyCycles = 0;
    bit  seen       = 1'b0;
    if (busy_out) busyCycles++;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk_in);
      if (done_out) begin
        seen     = 1'b1;
        doneEdge = k;
      end else if (busy_out) begin
        busyCycles++;
      end
    end
    checkOutput({tag, " doneEdge"}, 64'(doneEdge), 64'(expEdge));
    if (expBusy > 0) checkOutput({tag, " busyCycles"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({tag, " err"}, 64'(err_out), 64'(expErr));
    checkOutput({tag, " HI"}, 64'(HI_out), 64'(expHi));
    checkOutput({tag, " LO"}, 64'(LO_out), 64'(expLo));
    @(negedge clk_in);
    checkOutput({tag, " donePulse"}, {62'd0, done_out, err_out}, 64'd0);
  endtask

  initial begin
    int doneSeen;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    op_in    = 2'b00;
    A_in     = '0;
    B_in     = '0;
    hi_we_in = 1'b0;
    lo_we_in = 1'b0;
    flush_in = 1'b0;
    #12;
    checkOutput("reset ctrl", {61'd0, busy_out, done_out, err_out}, 64'd0);
    checkOutput("reset HILO", {HI_out, LO_out}, 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    applyStimulus(2'b01, 32'd4095, 32'd13121, 1'b0);
    waitDone("multu small", 33, 33, 32'h0000_0000, 32'h0333_DCBF, 1'b0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    waitDone("mult neg", 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitDone("multu max", 33, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    waitDone("div neg dividend", 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    waitDone("div neg divisor", 33, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(2'b11, 32'd13121, 32'd4095, 1'b0);
    waitDone("divu", 33, 33, 32'd836, 32'd3, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    waitDone("div overflow", 33, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // MTHI, then divide by zero must leave HI/LO alone
    @(negedge clk_in);
    hi_we_in = 1'b1;
    A_in     = 32'h1234_5678;
    @(negedge clk_in);
    hi_we_in = 1'b0;
    checkOutput("mthi", 64'(HI_out), 64'h1234_5678);
    applyStimulus(2'b11, 32'd99, 32'd0, 1'b0);
    waitDone("divu by zero", 1, 0, 32'h1234_5678, 32'h8000_0000, 1'b1);

    @(negedge clk_in);
    hi_we_in = 1'b1;
    lo_we_in = 1'b1;
    A_in     = 32'hCAFE_F00D;
    @(negedge clk_in);
    hi_we_in = 1'b0;
    lo_we_in = 1'b0;
    checkOutput("mthi+mtlo", {HI_out, LO_out}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Second start while busy is ignored; flush aborts with no done
    doneSeen = 0;
    applyStimulus(2'b00, 32'd5, 32'd5, 1'b0);
    repeat (8) @(negedge clk_in);
    start_in = 1'b1;
    A_in     = 32'd9;
    B_in     = 32'd9;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (9) @(negedge clk_in);
    checkOutput("busy before flush", 64'(busy_out), 64'd1);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    checkOutput("busy after flush", 64'(busy_out), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (done_out || busy_out) doneSeen++;
    end
    checkOutput("flush no done", 64'(doneSeen), 64'd0);
    checkOutput("flush HILO", {HI_out, LO_out}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Flush in IDLE drops a simultaneous start
    @(negedge clk_in);
    start_in = 1'b1;
    flush_in = 1'b1;
    op_in    = 2'b01;
    A_in     = 32'd3;
    B_in     = 32'd3;
    @(negedge clk_in);
    start_in = 1'b0;
    flush_in = 1'b0;
    checkOutput("idle flush drops start", 64'(busy_out), 64'd0);

    // Asynchronous reset in the middle of RUN
    applyStimulus(2'b00, 32'd5, 32'd5, 1'b0);
    repeat (5) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    checkOutput("async reset ctrl", {61'd0, busy_out, done_out, err_out}, 64'd0);
    checkOutput("async reset HILO", {HI_out, LO_out}, 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Start and MTLO together: start wins, LO ends up with the product
    applyStimulus(2'b00, 32'd5, 32'd5, 1'b1);
    checkOutput("start beats mtlo", 64'(LO_out), 64'd0);
    waitDone("mult after reset", 33, 33, 32'd0, 32'd25, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the MIPS32 core; successor to the combinational 32-bit add/sub block.
- Performs MULT, MULTU, DIV and DIVU over WIDTH cycles using shift-add multiply and restoring divide.
- Results go to internal HI/LO registers, readable by MFHI/MFLO and writable by MTHI/MTLO.
- Sits beside the ALU in EX; the pipeline stalls on busy_out.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; must be >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
start_in  input  1  start request; accepted only in IDLE
op_in  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_in
A_in  input  WIDTH  multiplicand / dividend
B_in  input  WIDTH  multiplier / divisor
hi_we_in  input  1  MTHI: write A_in into HI
lo_we_in  input  1  MTLO: write A_in into LO
flush_in  input  1  abort any operation in progress
busy_out  output  1  operation in progress
done_out  output  1  one-cycle completion pulse
err_out  output  1  one-cycle divide-by-zero pulse, coincident with done_out
HI_out  output  WIDTH  HI register
LO_out  output  WIDTH  LO register

Behaviour:
- Reset (rst_n_in low, asynchronous): state IDLE; busy_out, done_out and err_out 0; HI_out and LO_out 0; counter 0.
- States:
  - IDLE: accepts start_in, hi_we_in and lo_we_in.
  - RUN: one iteration per cycle; counter counts down from WIDTH.
  - FIX: sign correction, then HI/LO write.
  - DONE: single cycle with done_out=1, then IDLE.
- Start, at edge 0 while in IDLE with start_in=1:
  - Latch op_in.
  - Latch operand magnitudes (absolute value for signed ops) and the result sign bits.
  - Go to RUN with counter=WIDTH.
- RUN: counter decrements each edge; leaving RUN after WIDTH edges goes to FIX.
- FIX: one edge. Negate product/quotient/remainder as required, write HI/LO, go to DONE.
- Latency:
  - busy_out=1 from after edge 0 through the FIX cycle.
  - HI/LO hold the new value and done_out=1 in the cycle after edge WIDTH+1 (WIDTH=32: 34th cycle counting the start cycle as 1).
  - busy_out=0 in the DONE cycle.
- MULT/MULTU: 2*WIDTH-bit product; HI = upper half, LO = lower half.
- DIV/DIVU results: LO = quotient, HI = remainder.
- DIV signedness: quotient truncates toward zero; remainder takes the dividend's sign.
- DIV of most-negative value by -1: LO = most-negative value, HI = 0, err_out=0.
- Divide by zero (B_in=0 with op DIV or DIVU, detected at start):
  - Skip RUN and FIX; go directly to DONE.
  - done_out=1 and err_out=1 in the cycle after edge 1.
  - HI/LO unchanged.
- start_in while busy or in DONE: ignored; no queuing.
- MTHI/MTLO:
  - Honoured only in IDLE with start_in=0; the write is visible on the next cycle.
  - hi_we_in and lo_we_in may both be set; both registers then take A_in.
  - Ignored while busy_out=1 or in DONE.
  - start_in in the same cycle wins; the write is dropped.
- flush_in:
  - In RUN or FIX: next edge goes to IDLE; HI/LO unchanged; no done_out.
  - In DONE: done_out still completes this cycle.
  - In IDLE: takes priority over start_in; the start is dropped.
- Reset asserted mid-operation: immediate return to reset values; no done_out.
- done_out and err_out are never asserted for more than one cycle.

Decomposition:
- mdu_pkg holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state enum: IDLE, RUN, FIX, DONE
- One sub-module, mdu_step: combinational single-iteration datapath, parametrised by WIDTH.
  - Multiply mode: conditional add and right shift of the {acc, multiplier} pair.
  - Divide mode: trial subtract and left shift of the {rem, quotient} pair.
- mdu_iter owns the FSM, counter, sign handling and HI/LO registers.

Test Plan:
1. MULTU, A=4095, B=13121 -> after 34 cycles, done_out pulse; HI=0x00000000, LO=0x0333DCBF; busy_out high for exactly 33 cycles.
2. MULT, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=13121, B=4095 -> LO=3, HI=836. DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, err_out=0.
4. DIVU with B=0 after MTHI=0x12345678 -> done_out=1 and err_out=1 two cycles after start; HI remains 0x12345678.
5. Start MULT 5*5; pulse start_in with 9*9 at cycle 10; assert flush_in at cycle 20 -> no done_out, HI/LO keep their prior values, busy_out=0 after cycle 21.
6. Start MULT 5*5, then deassert rst_n_in mid-RUN asynchronously (not on a clock edge) -> all outputs 0 immediately. Then, in IDLE, assert start_in and lo_we_in together -> LO gets the product 25, not A_in.
